// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the writeback path and its arbiters.
package regfile_pkg;

   typedef logic [4:0] reg_addr_t;

   localparam reg_addr_t   ZR_ADDR   = 5'd31;
   localparam int unsigned NREGS     = 32;
   localparam int unsigned WB_DATA_W = 64;

   // Generic writeback request, reusable by any writeback source.
   typedef struct packed {
      logic                 valid;
      reg_addr_t            addr;
      logic [WB_DATA_W-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grants, pointer moves to the loser on every grant.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic prio_q, prio_d;

   always_comb begin
      gnt    = req;
      prio_d = prio_q;
      if (&req) begin
         gnt = prio_q ? 2'b10 : 2'b01;
      end
      if (gnt[0]) begin
         prio_d = 1'b1;
      end else if (gnt[1]) begin
         prio_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback,
// and produces read-bypass data for the two registered read ports.
module regfile_wr_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned N  = 64,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          a_valid,
   input  reg_addr_t     a_addr,
   input  logic [N-1:0]  a_data,
   output logic          a_ready,
   input  logic          b_valid,
   input  reg_addr_t     b_addr,
   input  logic [N-1:0]  b_data,
   output logic          b_ready,
   output logic          we3,
   output reg_addr_t     wa3,
   output logic [N-1:0]  wd3,
   input  reg_addr_t     ra1,
   input  reg_addr_t     ra2,
   output logic          fwd1_valid,
   output logic [N-1:0]  fwd1_data,
   output logic          fwd2_valid,
   output logic [N-1:0]  fwd2_data,
   output logic [CW-1:0] conflict_cnt
);

   logic          a_use, b_use;
   logic [1:0]    gnt;
   logic          we3_q, fwd1_valid_q, fwd2_valid_q;
   reg_addr_t     wa3_q;
   logic [N-1:0]  wd3_q, fwd1_data_q, fwd2_data_q;
   logic [CW-1:0] cnt_q;

   assign a_use = a_valid && (a_addr != ZR_ADDR);
   assign b_use = b_valid && (b_addr != ZR_ADDR);

   rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     ({b_use, a_use}),
      .gnt     (gnt)
   );

   // Zero-register writes are swallowed here, so they are always ready.
   assign a_ready = reset_n && ((a_addr == ZR_ADDR) || gnt[0]);
   assign b_ready = reset_n && ((b_addr == ZR_ADDR) || gnt[1]);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         we3_q        <= 1'b0;
         wa3_q        <= '0;
         wd3_q        <= '0;
         fwd1_valid_q <= 1'b0;
         fwd1_data_q  <= '0;
         fwd2_valid_q <= 1'b0;
         fwd2_data_q  <= '0;
         cnt_q        <= '0;
      end else begin
         we3_q <= |gnt;
         if (gnt[0]) begin
            wa3_q <= a_addr;
            wd3_q <= a_data;
         end else if (gnt[1]) begin
            wa3_q <= b_addr;
            wd3_q <= b_data;
         end
         // Reads are registered, so a same-edge write is only visible via bypass.
         fwd1_valid_q <= we3_q && (wa3_q == ra1) && (ra1 != ZR_ADDR);
         fwd2_valid_q <= we3_q && (wa3_q == ra2) && (ra2 != ZR_ADDR);
         fwd1_data_q  <= wd3_q;
         fwd2_data_q  <= wd3_q;
         if (a_use && b_use && (cnt_q != '1)) begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
         end
      end
   end

   assign we3          = we3_q;
   assign wa3          = wa3_q;
   assign wd3          = wd3_q;
   assign fwd1_valid   = fwd1_valid_q;
   assign fwd1_data    = fwd1_data_q;
   assign fwd2_valid   = fwd2_valid_q;
   assign fwd2_data    = fwd2_data_q;
   assign conflict_cnt = cnt_q;

endmodule
